// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the instruction store.
// A count byte N is followed by 4N bytes forming big-endian 32-bit words, written to
// mem[0..N-1]. After the last word the processor is released from reset (cpu_rstd).
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte covering the count byte and all data bytes; a mismatch parks the loader in ERR.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  pc,
  output logic [31:0] ins,
  output logic        cpu_rstd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [2:0] ST_COUNT = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM  = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;    // word count; 0 encodes the full depth
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;    // first three bytes of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [31:0] mem_q [Depth];
  logic        mem_we;
  logic        xfer;

  assign xfer = in_valid & in_ready;

  // Handshake and status outputs decoded from the state register only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_rstd = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_COUNT: in_ready = 1'b1;
      ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_ERR: err = 1'b1;
`endif
      ST_RUN: begin
        done     = 1'b1;
        cpu_rstd = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: count capture, byte assembly, word write and termination.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    mem_we  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (xfer) begin
      case (state_q)
        ST_COUNT: begin
          cnt_d   = in_data[ADDR_W-1:0];
          widx_d  = '0;
          lane_d  = 2'd0;
          asm_d   = 24'd0;
          state_d = ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = in_data;
`endif
        end
        ST_DATA: begin
          asm_d  = {asm_q[15:0], in_data};
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (lane_q == 2'd3) begin
            mem_we = 1'b1;
            widx_d = widx_q + ADDR_W'(1);
            // cnt_q - 1 wraps to the last index when the count encodes full depth
            if (widx_q == cnt_q - ADDR_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_RUN;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: state_d = (in_data == csum_q) ? ST_RUN : ST_ERR;
`endif
        default: ;
      endcase
    end
  end

  // Control state, asynchronously reset.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= ST_COUNT;
      cnt_q   <= '0;
      widx_q  <= '0;
      lane_q  <= 2'd0;
      asm_q   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Instruction store write; deliberately not reset so loaded words survive rstd.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx_q] <= {asm_q, in_data};
    end
  end

  assign ins = mem_q[pc[ADDR_W-1:0]];

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Define IMEM_LOADER_CHECKSUM_EN here as in the RTL
// build to exercise the checksum path.
module tb_imem_loader;

  logic        clk;
  logic        rstd;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pc;
  logic [31:0] ins;
  logic        cpu_rstd;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rstd     (rstd),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pc       (pc),
    .ins      (ins),
    .cpu_rstd (cpu_rstd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    pc = a;
    #1;
    chk32(tag, ins, exp);
  endtask

  // One byte transfer: offered at a negedge, consumed at the next posedge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("send_ready", in_ready, 1'b1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstd = 1'b0;
    #3;
    @(negedge clk);
    rstd = 1'b1;
  endtask

  // Two-word program 12345678 / 9ABCDEF0, optional idle cycles between bytes.
  task automatic load_two(input int stall);
    logic [7:0] s [9];
    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 9; i++) begin
      send(s[i]);
      if (i < 8) chk1("two_not_released", cpu_rstd, 1'b0);
      if (i == 0) chk1("two_busy", busy, 1'b1);
      repeat (stall) @(negedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk1("two_csum_wait", cpu_rstd, 1'b0);
    send(8'h02);
`endif
    chk1("two_cpu_rstd", cpu_rstd, 1'b1);
    chk1("two_done", done, 1'b1);
    chk1("two_busy_low", busy, 1'b0);
    chk1("two_ready_low", in_ready, 1'b0);
    rd("two_mem1", 8'd1, 32'h9ABCDEF0);
    rd("two_mem0", 8'd0, 32'h12345678);
  endtask

  initial begin
    rstd     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pc       = 8'h00;
    repeat (2) @(negedge clk);
    rstd = 1'b1;
    #1;
    chk1("rst_ready", in_ready, 1'b1);
    chk1("rst_cpu_rstd", cpu_rstd, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);

    // Back-to-back two-word load
    load_two(0);

    // Same stream with 3 idle cycles between bytes
    pulse_reset();
    chk1("rerun_cpu_rstd", cpu_rstd, 1'b0);
    load_two(3);

    // Full depth: count 0 means 256 words, word i = i
    pulse_reset();
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'(i));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk1("full_done", done, 1'b1);
    chk1("full_ready_low", in_ready, 1'b0);
    rd("full_mem255", 8'd255, 32'h000000FF);
    rd("full_mem0", 8'd0, 32'h00000000);
    rd("full_mem1", 8'd1, 32'h00000001);
    rd("full_mem128", 8'd128, 32'h00000080);
    // Extra bytes in RUN must be ignored
    @(negedge clk);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk1("full_extra_done", done, 1'b1);
    chk1("full_extra_ready", in_ready, 1'b0);
    rd("full_extra_mem255", 8'd255, 32'h000000FF);

    // Reset mid-load: partial word 1 discarded
    pulse_reset();
    send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'hEE); send(8'hFF);
    chk1("mid_busy", busy, 1'b1);
    pulse_reset();
    #1;
    chk1("mid_ready", in_ready, 1'b1);
    chk1("mid_busy_low", busy, 1'b0);
    chk1("mid_cpu_rstd", cpu_rstd, 1'b0);
    rd("mid_mem0", 8'd0, 32'hAABBCCDD);
    rd("mid_mem1", 8'd1, 32'h00000001);
    send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h45);
`endif
    chk1("mid_reload_done", done, 1'b1);
    rd("mid_reload_mem0", 8'd0, 32'h11223344);
    rd("mid_reload_mem1", 8'd1, 32'h00000001);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum parks in ERR; correct one releases
    pulse_reset();
    send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hFF);
    chk1("csum_err", err, 1'b1);
    chk1("csum_cpu_rstd", cpu_rstd, 1'b0);
    chk1("csum_done", done, 1'b0);
    chk1("csum_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk1("csum_err_hold", err, 1'b1);
    pulse_reset();
    #1;
    chk1("csum_err_clear", err, 1'b0);
    send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    chk1("csum_ok_done", done, 1'b1);
    chk1("csum_ok_err", err, 1'b0);
    rd("csum_ok_mem0", 8'd0, 32'h01020304);
`else
    chk1("no_csum_err", err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader for the instruction memory. Accepts a length-prefixed program over a byte valid/ready handshake and assembles big-endian 32-bit words into a 256-entry instruction store. It then releases the processor from reset. It replaces the file-initialised instruction ROM: fetch reads `ins` through the combinational port, and `cpu_rstd` drives the processor's `rstd`.

## Interface
- `ADDR_W`, default 8: word-address width; depth = 2^`ADDR_W`; legal range 1..8.
- `clk` input 1: clock; all state changes on posedge.
- `rstd` input 1: reset, asynchronous, active-low.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader can accept a byte; a byte transfers on a posedge with `in_valid` && `in_ready`.
- `pc` input 8: fetch address; low `ADDR_W` bits used.
- `ins` output 32: `mem[pc]`, combinational.
- `cpu_rstd` output 1: processor reset, active-low, registered.
- `busy` output 1: load in progress (state DATA or CSUM).
- `done` output 1: program loaded; processor running.
- `err` output 1: checksum failure (only with checksum compiled in; otherwise constant 0).

## Operation
- **States:**
  - COUNT: wait for count byte.
  - DATA: collect 4N bytes.
  - CSUM: wait for checksum byte; present only with the macro.
  - RUN: terminal.
  - ERR: terminal; present only with the macro.
- **Outputs by state:**
  - `in_ready` = 1 in COUNT, DATA, CSUM; 0 in RUN, ERR. Decoded from the state register, no combinational path from `in_valid`.
- **COUNT:**
  - Accepted byte b gives N = b[`ADDR_W`-1:0]; N = 0 means 2^`ADDR_W` words.
  - Clears the word index `widx` and byte lane counter `lane`.
  - Next state is DATA.
- **DATA:**
  - Each accepted byte shifts into a 24-bit assembly register. Byte order is big-endian: lane 0 becomes `ins[31:24]` and lane 3 becomes `ins[7:0]`.
  - On lane 3 acceptance, `mem[widx]` <= {assembly, `in_data`} on the same edge, `widx` increments and `lane` returns to 0.
  - When lane 3 is accepted with `widx` == N-1, the next state is CSUM (macro on) or RUN (macro off).
- **Unwritten memory:** words at `widx` ≥ N keep their prior contents. Memory is never cleared, including on reset.
- **RUN:** `cpu_rstd` = 1, `done` = 1. Further stream bytes are not accepted. Exit only via `rstd`.
- **Read port:** `ins` is readable in every state; during loading it may show partial contents, with no hazard protection required.
- **Write/read collision:** a write to the address currently on `pc` shows the new word on `ins` after the write edge.

## Timing
- **Reset values:** state COUNT, `widx` 0, `lane` 0, assembly register 0, running checksum 0, `cpu_rstd` 0, `done` 0, `busy` 0, `err` 0. `in_ready` is 1 from reset deassertion.
- **Release latency:** last data byte (or checksum byte) accepted at edge k. `mem` write lands at edge k, and `cpu_rstd`, `done` rise after edge k (same edge, registered). `busy` falls after edge k.
- **Throughput:** one byte per cycle sustained; total load = 1 + 4N (+1) accepted bytes.
- **Handshake:**
  - `in_valid` low stalls with no state change.
  - A byte held across cycles with `in_ready` = 1 is consumed once per edge; the producer must drop or advance after a transfer.
- **`rstd` asserted mid-load:** immediate return to COUNT with `cpu_rstd` 0. Already written words remain. A partially assembled word is discarded (never written).
- **`rstd` asserted in RUN:** the processor re-enters reset through `cpu_rstd` and a new load is required.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR covers the count byte and all data bytes.
  - After the last data byte the loader enters CSUM and accepts one byte.
  - If the byte equals the XOR: RUN.
  - Otherwise: ERR, with `err` = 1, `cpu_rstd` = 0, `done` = 0, `in_ready` = 0, until `rstd`.
- Not defined:
  - No CSUM or ERR state and no XOR register.
  - The last data byte goes straight to RUN.
  - `err` is tied to 0.

## Test plan
- **Reset values:** `rstd` pulse low. Then `in_ready` = 1, `cpu_rstd` = 0, `done` = 0, `busy` = 0, `err` = 0.
- **Two-word load, back to back:** stream 0x02, 12 34 56 78, 9A BC DE F0 (with the macro, plus checksum 0x02).
  - `mem[0]` = 0x12345678, `mem[1]` = 0x9ABCDEF0.
  - `cpu_rstd` and `done` rise one edge after the final byte; `pc` = 1 gives `ins` = 0x9ABCDEF0.
- **Stalls:** same stream with `in_valid` low for 3 cycles between every byte. Memory contents are identical, and `cpu_rstd` rises only after the final transfer.
- **Full depth:** count 0x00 with 1024 data bytes where word i = i. Writes `mem[255]` = 0x000000FF; then RUN. Extra bytes after that are not accepted (`in_ready` = 0).
- **Reset mid-load:** count 0x03, one word AABBCCDD, two bytes of word 1, then `rstd` pulse.
  - State is COUNT with `mem[0]` = 0xAABBCCDD retained and `mem[1]` unchanged.
  - A following 1-word load of 11223344 gives `mem[0]` = 0x11223344 and `done`.
- **Checksum failure** (`IMEM_LOADER_CHECKSUM_EN`): count 0x01, 01 02 03 04, checksum 0xFF (correct value 0x05).
  - Result: `err` = 1, `cpu_rstd` stays 0, `in_ready` = 0.
  - After an `rstd` pulse, a reload with checksum 0x05 reaches `done` = 1.
